// File: rtl/sd_emmc_cmd_responder_pkg.sv
// Shared constants for the card-side CMD line responder: response codes, frame lengths,
// FSM encodings and the CRC7 single-bit update.
package sd_emmc_cmd_responder_pkg;

  // Response codes follow the host setting {long, expect}; 2'b10 carries no frame
  localparam logic [1:0] RESP_NONE  = 2'b00;
  localparam logic [1:0] RESP_SHORT = 2'b01;
  localparam logic [1:0] RESP_LONG  = 2'b11;

  localparam int CMD_FRAME_LEN = 48;
  localparam int RESP_LONG_LEN = 136;

  // x^7 + x^3 + 1 with the x^7 term implied
  localparam logic [6:0] CRC7_POLY = 7'h09;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_RX    = 3'd1;
  localparam state_t ST_CHECK = 3'd2;
  localparam state_t ST_WAIT  = 3'd3;
  localparam state_t ST_TX    = 3'd4;
  localparam state_t ST_BUSY  = 3'd5;

  function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic bit_in);
    logic fb;
    fb = bit_in ^ crc[6];
    return {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
  endfunction

endpackage

// File: rtl/sd_emmc_cmd_responder_crc7.sv
// Serial CRC7 accumulator shared by the receive and transmit paths.
// clear_i restarts from zero; when en_i is also set the first bit is folded in the same cycle.
module sd_emmc_cmd_responder_crc7
  import sd_emmc_cmd_responder_pkg::*;
(
  input  logic       sd_clk,
  input  logic       rst,
  input  logic       clear_i,
  input  logic       en_i,
  input  logic       bit_i,
  output logic [6:0] crc_o
);

  logic [6:0] crc_q;
  logic [6:0] crc_d;
  logic [6:0] crc_base;

  // Next CRC value: optional clear, then optional one-bit update
  always_comb begin
    crc_base = clear_i ? 7'h00 : crc_q;
    if (en_i) begin
      crc_d = crc7_step(crc_base, bit_i);
    end else begin
      crc_d = crc_base;
    end
  end

  // CRC state register
  always_ff @(posedge sd_clk or posedge rst) begin
    if (rst) begin
      crc_q <= 7'h00;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/sd_emmc_cmd_responder.sv
// Card-side CMD line endpoint: receives and checks 48-bit host commands, hands them to the
// card model, and serialises the short/long response, optionally followed by DAT0 busy.
module sd_emmc_cmd_responder
  import sd_emmc_cmd_responder_pkg::*;
#(
  parameter int NCR_CYCLES    = 2,
  parameter int RESP_WAIT_MAX = 64
)
(
  input  logic         sd_clk,
  input  logic         rst,
  input  logic         cmd_i,
  output logic         cmd_o,
  output logic         cmd_oe,
  output logic         dat0_o,
  output logic         dat0_oe,
  output logic         cmd_valid_o,
  output logic [5:0]   cmd_index_o,
  output logic [31:0]  cmd_arg_o,
  output logic         cmd_err_o,
  output logic         resp_ready_o,
  input  logic         resp_valid_i,
  input  logic [1:0]   resp_type_i,
  input  logic         resp_busy_i,
  input  logic [119:0] resp_i,
  input  logic         busy_i,
  output logic         resp_miss_o
);

  // The TX decision is registered, so the start bit lands one cycle after it
  localparam logic [6:0] NCR_GO     = 7'(NCR_CYCLES - 2);
  localparam logic [6:0] WAIT_LAST  = 7'(RESP_WAIT_MAX - 1);
  localparam logic [7:0] RX_LAST    = 8'(CMD_FRAME_LEN - 1);
  localparam logic [7:0] SHORT_LAST = 8'(CMD_FRAME_LEN - 1);
  localparam logic [7:0] LONG_LAST  = 8'(RESP_LONG_LEN - 1);
  localparam logic [7:0] SHORT_CRC  = 8'(CMD_FRAME_LEN - 8);
  localparam logic [7:0] LONG_CRC   = 8'(RESP_LONG_LEN - 8);

  state_t         state_q, state_d;
  logic [7:0]     bit_cnt_q, bit_cnt_d;
  logic [47:0]    rx_sr_q, rx_sr_d;
  logic [5:0]     idx_q, idx_d;
  logic [31:0]    arg_q, arg_d;
  logic           valid_q, valid_d;
  logic           err_q, err_d;
  logic           miss_q, miss_d;
  logic           ready_q, ready_d;
  logic [6:0]     ncr_q, ncr_d;
  logic [6:0]     wait_cnt_q, wait_cnt_d;
  logic           have_q, have_d;
  logic           long_q, long_d;
  logic           busy_flag_q, busy_flag_d;
  logic [135:0]   tx_sr_q, tx_sr_d;
  logic [7:0]     tx_cnt_q, tx_cnt_d;
  logic           cmd_o_q, cmd_o_d;
  logic           cmd_oe_q, cmd_oe_d;
  logic           dat0_o_q, dat0_o_d;
  logic           dat0_oe_q, dat0_oe_d;

  logic           crc_clr;
  logic           crc_en;
  logic           crc_bit;
  logic [6:0]     crc_val;
  logic           accept;
  logic           resp_has_frame;
  logic           frame_ok;
  logic [7:0]     tx_next;
  logic [7:0]     tx_last;
  logic [7:0]     tx_crc_pos;
  logic [7:0]     tx_hdr;

  sd_emmc_cmd_responder_crc7 u_crc7 (
    .sd_clk  (sd_clk),
    .rst     (rst),
    .clear_i (crc_clr),
    .en_i    (crc_en),
    .bit_i   (crc_bit),
    .crc_o   (crc_val)
  );

  assign accept     = ready_q & resp_valid_i;
  assign frame_ok   = ~rx_sr_q[47] & rx_sr_q[46] & rx_sr_q[0] & (rx_sr_q[7:1] == crc_val);
  assign tx_next    = tx_cnt_q + 8'd1;
  assign tx_last    = long_q ? LONG_LAST : SHORT_LAST;
  assign tx_crc_pos = long_q ? LONG_CRC : SHORT_CRC;
  assign tx_hdr     = long_q ? 8'd8 : 8'd0;

  // Decode whether the offered response type carries a CMD frame
  always_comb begin
    case (resp_type_i)
      RESP_SHORT: resp_has_frame = 1'b1;
      RESP_LONG:  resp_has_frame = 1'b1;
      RESP_NONE:  resp_has_frame = 1'b0;
      default:    resp_has_frame = 1'b0;
    endcase
  end

  // Protocol FSM and datapath next-state
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    rx_sr_d     = rx_sr_q;
    idx_d       = idx_q;
    arg_d       = arg_q;
    valid_d     = 1'b0;
    err_d       = 1'b0;
    miss_d      = 1'b0;
    ncr_d       = ncr_q;
    wait_cnt_d  = wait_cnt_q;
    have_d      = have_q;
    long_d      = long_q;
    busy_flag_d = busy_flag_q;
    tx_sr_d     = tx_sr_q;
    tx_cnt_d    = tx_cnt_q;
    cmd_o_d     = cmd_o_q;
    cmd_oe_d    = cmd_oe_q;
    crc_clr     = 1'b0;
    crc_en      = 1'b0;
    crc_bit     = cmd_i;

    case (state_q)
      ST_IDLE: begin
        if (!cmd_i) begin
          state_d   = ST_RX;
          bit_cnt_d = 8'd1;
          rx_sr_d   = {rx_sr_q[46:0], cmd_i};
          crc_clr   = 1'b1;
          crc_en    = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_RX: begin
        rx_sr_d   = {rx_sr_q[46:0], cmd_i};
        crc_en    = (bit_cnt_q < SHORT_CRC);
        bit_cnt_d = bit_cnt_q + 8'd1;
        if (bit_cnt_q == RX_LAST) begin
          state_d = ST_CHECK;
        end else begin
          state_d = ST_RX;
        end
      end

      ST_CHECK: begin
        if (frame_ok) begin
          valid_d    = 1'b1;
          idx_d      = rx_sr_q[45:40];
          arg_d      = rx_sr_q[39:8];
          ncr_d      = 7'd0;
          wait_cnt_d = 7'd0;
          have_d     = 1'b0;
          state_d    = ST_WAIT;
        end else begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end
      end

      ST_WAIT: begin
        if (accept && !resp_has_frame) begin
          state_d = ST_IDLE;
        end else begin
          if (accept) begin
            have_d      = 1'b1;
            long_d      = (resp_type_i == RESP_LONG);
            busy_flag_d = resp_busy_i;
            tx_sr_d     = (resp_type_i == RESP_LONG) ? {1'b0, 6'h3F, resp_i, 9'd0}
                                                     : {1'b0, idx_q, resp_i[119:88], 97'd0};
          end else begin
            have_d = have_q;
          end
          // Start bit is driven straight from this decision; it is also the first CRC bit of a short frame
          if (have_d && (ncr_q >= NCR_GO)) begin
            state_d  = ST_TX;
            cmd_o_d  = 1'b0;
            cmd_oe_d = 1'b1;
            tx_cnt_d = 8'd0;
            crc_clr  = 1'b1;
            crc_en   = ~long_d;
            crc_bit  = 1'b0;
          end else if (!have_d && (wait_cnt_q == WAIT_LAST)) begin
            miss_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            state_d    = ST_WAIT;
            ncr_d      = (ncr_q == 7'h7F) ? ncr_q : ncr_q + 7'd1;
            wait_cnt_d = (wait_cnt_q == 7'h7F) ? wait_cnt_q : wait_cnt_q + 7'd1;
          end
        end
      end

      ST_TX: begin
        if (tx_cnt_q == tx_last) begin
          cmd_oe_d = 1'b0;
          cmd_o_d  = 1'b1;
          state_d  = busy_flag_q ? ST_BUSY : ST_IDLE;
        end else begin
          tx_cnt_d = tx_next;
          state_d  = ST_TX;
          // CRC is final once the last payload bit is on the line; park it and the end bit in the shifter
          if (tx_next == tx_crc_pos) begin
            cmd_o_d = crc_val[6];
            tx_sr_d = {crc_val[5:0], 1'b1, 129'd0};
          end else begin
            cmd_o_d = tx_sr_q[135];
            tx_sr_d = {tx_sr_q[134:0], 1'b0};
            crc_en  = (tx_next >= tx_hdr) && (tx_next < tx_crc_pos);
            crc_bit = tx_sr_q[135];
          end
        end
      end

      ST_BUSY: begin
        if (!busy_i) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_BUSY;
        end
      end

      default: begin
        state_d  = ST_IDLE;
        cmd_oe_d = 1'b0;
        cmd_o_d  = 1'b1;
      end
    endcase

    dat0_oe_d = (state_d == ST_BUSY);
    dat0_o_d  = ~dat0_oe_d;
    ready_d   = (state_d == ST_WAIT) && !have_d;
  end

  // State, datapath and registered outputs
  always_ff @(posedge sd_clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= 8'd0;
      rx_sr_q     <= 48'd0;
      idx_q       <= 6'd0;
      arg_q       <= 32'd0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
      miss_q      <= 1'b0;
      ready_q     <= 1'b0;
      ncr_q       <= 7'd0;
      wait_cnt_q  <= 7'd0;
      have_q      <= 1'b0;
      long_q      <= 1'b0;
      busy_flag_q <= 1'b0;
      tx_sr_q     <= 136'd0;
      tx_cnt_q    <= 8'd0;
      cmd_o_q     <= 1'b1;
      cmd_oe_q    <= 1'b0;
      dat0_o_q    <= 1'b1;
      dat0_oe_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_sr_q     <= rx_sr_d;
      idx_q       <= idx_d;
      arg_q       <= arg_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
      miss_q      <= miss_d;
      ready_q     <= ready_d;
      ncr_q       <= ncr_d;
      wait_cnt_q  <= wait_cnt_d;
      have_q      <= have_d;
      long_q      <= long_d;
      busy_flag_q <= busy_flag_d;
      tx_sr_q     <= tx_sr_d;
      tx_cnt_q    <= tx_cnt_d;
      cmd_o_q     <= cmd_o_d;
      cmd_oe_q    <= cmd_oe_d;
      dat0_o_q    <= dat0_o_d;
      dat0_oe_q   <= dat0_oe_d;
    end
  end

  assign cmd_o        = cmd_o_q;
  assign cmd_oe       = cmd_oe_q;
  assign dat0_o       = dat0_o_q;
  assign dat0_oe      = dat0_oe_q;
  assign cmd_valid_o  = valid_q;
  assign cmd_index_o  = idx_q;
  assign cmd_arg_o    = arg_q;
  assign cmd_err_o    = err_q;
  assign resp_ready_o = ready_q;
  assign resp_miss_o  = miss_q;

endmodule

// File: tb/tb_sd_emmc_cmd_responder.sv
// Randomised bench for sd_emmc_cmd_responder: host frames and responses are built from the
// CRC7 definition by polynomial long division and compared bit-for-bit with the CMD/DAT0 lines.
module tb_sd_emmc_cmd_responder;

  localparam int NCR      = 2;
  localparam int WAIT_MAX = 64;
  localparam int M_MISS = 0, M_NONE = 1, M_SHORT = 2, M_LONG = 3;

  logic         sd_clk = 1'b0;
  logic         rst = 1'b1;
  logic         cmd_i = 1'b1;
  logic         cmd_o, cmd_oe, dat0_o, dat0_oe;
  logic         cmd_valid_o, cmd_err_o, resp_ready_o, resp_miss_o;
  logic [5:0]   cmd_index_o;
  logic [31:0]  cmd_arg_o;
  logic         resp_valid_i = 1'b0;
  logic [1:0]   resp_type_i = 2'b00;
  logic         resp_busy_i = 1'b0;
  logic [119:0] resp_i = '0;
  logic         busy_i = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  sd_emmc_cmd_responder #(.NCR_CYCLES(NCR), .RESP_WAIT_MAX(WAIT_MAX)) dut (
    .sd_clk(sd_clk), .rst(rst), .cmd_i(cmd_i), .cmd_o(cmd_o), .cmd_oe(cmd_oe),
    .dat0_o(dat0_o), .dat0_oe(dat0_oe), .cmd_valid_o(cmd_valid_o), .cmd_index_o(cmd_index_o),
    .cmd_arg_o(cmd_arg_o), .cmd_err_o(cmd_err_o), .resp_ready_o(resp_ready_o),
    .resp_valid_i(resp_valid_i), .resp_type_i(resp_type_i), .resp_busy_i(resp_busy_i),
    .resp_i(resp_i), .busy_i(busy_i), .resp_miss_o(resp_miss_o)
  );

  always #5 sd_clk = ~sd_clk;

  task automatic check_eq(input string tag, input logic [135:0] act, input logic [135:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Remainder of M(x)*x^7 divided by x^7+x^3+1, message = low n bits of data, MSB first
  function automatic logic [6:0] crc7_div(input logic [135:0] data, input int n);
    logic [7:0] r;
    logic       nb;
    r = 8'd0;
    for (int i = n - 1; i >= -7; i--) begin
      if (i >= 0) nb = data[i];
      else        nb = 1'b0;
      r = {r[6:0], nb};
      if (r[7]) r = r ^ 8'h89;
    end
    return r[6:0];
  endfunction

  function automatic logic [47:0] cmd_frame(input logic [5:0] idx, input logic [31:0] arg);
    logic [39:0] b;
    b = {2'b01, idx, arg};
    return {b, crc7_div({96'd0, b}, 40), 1'b1};
  endfunction

  task automatic send_cmd(input logic [47:0] f);
    for (int i = 47; i >= 0; i--) begin
      @(negedge sd_clk);
      cmd_i = f[i];
    end
    @(negedge sd_clk);
    cmd_i = 1'b1;
    @(negedge sd_clk);
  endtask

  task automatic expect_silence(input string tag, input int cycles);
    int act;
    act = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge sd_clk);
      if (cmd_oe || dat0_oe || resp_ready_o) act++;
    end
    check_eq(tag, act, 0);
  endtask

  // One command/response exchange; corrupt: 0 good, 1 CRC bit, 2 transmission bit, 3 end bit
  task automatic run_txn(input logic [5:0] idx, input logic [31:0] arg, input int corrupt,
                         input int mode, input int k, input logic bflag, input int nbusy,
                         input logic [119:0] payload);
    logic [47:0]  f;
    logic [135:0] exp_frame, got_frame;
    logic [39:0]  b40;
    int           len, d, cnt, exp_d;
    logic         good, got, oe_ok, d0_ok;
    f = cmd_frame(idx, arg);
    case (corrupt)
      1: f[1 + $urandom_range(0, 6)] ^= 1'b1;
      2: f[46] = 1'b0;
      3: f[0] = 1'b0;
      default: ;
    endcase
    good = (corrupt == 0);
    send_cmd(f);
    check_eq("cmd_valid", cmd_valid_o, good);
    check_eq("cmd_err", cmd_err_o, !good);
    if (!good) begin
      expect_silence("no_resp_after_err", 10);
      return;
    end
    check_eq("cmd_index", cmd_index_o, idx);
    check_eq("cmd_arg", cmd_arg_o, arg);
    check_eq("resp_ready", resp_ready_o, 1'b1);

    if (mode == M_MISS) begin
      cnt = 0;
      while (resp_ready_o && cnt < 200) begin
        cnt++;
        @(negedge sd_clk);
      end
      check_eq("ready_cycles", cnt, WAIT_MAX);
      check_eq("miss_pulse", resp_miss_o, 1'b1);
      @(negedge sd_clk);
      check_eq("miss_one_cycle", resp_miss_o, 1'b0);
      return;
    end

    repeat (k) @(negedge sd_clk);
    resp_valid_i = 1'b1;
    resp_i       = payload;
    resp_busy_i  = bflag;
    busy_i       = 1'b1;
    if (mode == M_NONE) begin
      resp_type_i = ($urandom_range(0, 1) == 1) ? 2'b10 : 2'b00;
      @(negedge sd_clk);
      resp_valid_i = 1'b0;
      check_eq("none_ready_drop", resp_ready_o, 1'b0);
      expect_silence("none_no_frame", 8);
      busy_i = 1'b0;
      return;
    end
    resp_type_i = (mode == M_LONG) ? 2'b11 : 2'b01;

    exp_d = ((NCR > k + 2) ? NCR : k + 2) - 1 - k;
    d = 0;
    got = 1'b0;
    while (d < 100 && !got) begin
      @(negedge sd_clk);
      resp_valid_i = 1'b0;
      d++;
      got = cmd_oe;
    end
    check_eq("start_latency", d, exp_d);
    if (!got) return;

    if (mode == M_LONG) begin
      len = 136;
      exp_frame = {8'h3F, payload, crc7_div({16'd0, payload}, 120), 1'b1};
    end else begin
      len = 48;
      b40 = {2'b00, idx, payload[119:88]};
      exp_frame = {88'd0, b40, crc7_div({96'd0, b40}, 40), 1'b1};
    end
    got_frame = '0;
    got_frame[len - 1] = cmd_o;
    oe_ok = 1'b1;
    for (int j = len - 2; j >= 0; j--) begin
      @(negedge sd_clk);
      got_frame[j] = cmd_o;
      if (!cmd_oe) oe_ok = 1'b0;
    end
    check_eq("resp_frame", got_frame, exp_frame);
    check_eq("cmd_oe_held", oe_ok, 1'b1);

    // busy_i is high during the end-bit cycle and the following nbusy-1 cycles
    cnt = 0;
    d0_ok = 1'b1;
    for (int j = 1; j <= 12; j++) begin
      @(negedge sd_clk);
      if (j == 1) begin
        check_eq("cmd_oe_release", cmd_oe, 1'b0);
        check_eq("cmd_idle_high", cmd_o, 1'b1);
      end
      if (dat0_oe) begin
        cnt++;
        if (dat0_o !== 1'b0) d0_ok = 1'b0;
      end
      if (j >= nbusy) busy_i = 1'b0;
    end
    check_eq("busy_cycles", cnt, bflag ? nbusy : 0);
    check_eq("busy_drive_low", d0_ok, 1'b1);
    check_eq("dat0_released", dat0_oe, 1'b0);
    resp_busy_i = 1'b0;
  endtask

  function automatic logic [119:0] rand_payload();
    logic [127:0] w;
    w = {$urandom, $urandom, $urandom, $urandom};
    return w[119:0];
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [119:0] pl;
    int           d;
    repeat (3) @(negedge sd_clk);
    check_eq("rst_cmd_o", cmd_o, 1'b1);
    check_eq("rst_cmd_oe", cmd_oe, 1'b0);
    check_eq("rst_dat0_o", dat0_o, 1'b1);
    check_eq("rst_dat0_oe", dat0_oe, 1'b0);
    check_eq("rst_pulses", {cmd_valid_o, cmd_err_o, resp_miss_o, resp_ready_o}, 4'b0000);
    check_eq("rst_index_arg", {cmd_index_o, cmd_arg_o}, 38'd0);
    rst = 1'b0;
    repeat (2) @(negedge sd_clk);

    // CMD0 literal frame
    send_cmd(48'h40_0000_0000_95);
    check_eq("cmd0_valid", cmd_valid_o, 1'b1);
    check_eq("cmd0_err", cmd_err_o, 1'b0);
    check_eq("cmd0_index", cmd_index_o, 6'd0);
    check_eq("cmd0_arg", cmd_arg_o, 32'd0);
    resp_valid_i = 1'b1;
    resp_type_i  = 2'b00;
    @(negedge sd_clk);
    resp_valid_i = 1'b0;
    expect_silence("cmd0_no_resp", 6);

    // CMD17 with CRC byte 0x54 instead of 0x55
    send_cmd(48'h51_0000_0000_54);
    check_eq("cmd17_bad_err", cmd_err_o, 1'b1);
    check_eq("cmd17_bad_valid", cmd_valid_o, 1'b0);
    expect_silence("cmd17_bad_no_resp", 10);

    run_txn(6'd17, 32'd0, 0, M_SHORT, 0, 1'b0, 1, {32'h0000_0900, 88'd0});
    run_txn(6'd2, 32'd0, 0, M_LONG, 1, 1'b0, 1, rand_payload());
    run_txn(6'd7, 32'h1234_0000, 0, M_SHORT, 0, 1'b1, 10, rand_payload());
    run_txn(6'd13, $urandom, 0, M_MISS, 0, 1'b0, 1, rand_payload());
    run_txn(6'd55, $urandom, 2, M_SHORT, 0, 1'b0, 1, rand_payload());
    run_txn(6'd55, $urandom, 3, M_SHORT, 0, 1'b0, 1, rand_payload());

    for (int t = 0; t < 16; t++) begin
      run_txn(6'($urandom_range(0, 63)), $urandom,
              ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0,
              int'($urandom_range(0, 3)), int'($urandom_range(0, 4)),
              1'($urandom_range(0, 1)), int'($urandom_range(1, 10)), rand_payload());
    end

    // resp_valid_i outside WAIT_RESP must not start a frame
    resp_valid_i = 1'b1;
    resp_type_i  = 2'b01;
    expect_silence("idle_resp_ignored", 6);
    resp_valid_i = 1'b0;

    // Asynchronous reset in the middle of a long response
    send_cmd(cmd_frame(6'd2, 32'd0));
    check_eq("rsttx_valid", cmd_valid_o, 1'b1);
    pl = rand_payload();
    resp_i       = pl;
    resp_type_i  = 2'b11;
    resp_valid_i = 1'b1;
    d = 0;
    @(negedge sd_clk);
    resp_valid_i = 1'b0;
    while (!cmd_oe && d < 20) begin
      @(negedge sd_clk);
      d++;
    end
    check_eq("rsttx_started", cmd_oe, 1'b1);
    repeat (5) @(negedge sd_clk);
    rst = 1'b1;
    #1;
    check_eq("rsttx_cmd_oe", cmd_oe, 1'b0);
    check_eq("rsttx_cmd_o", cmd_o, 1'b1);
    check_eq("rsttx_index", cmd_index_o, 6'd0);
    @(negedge sd_clk);
    rst = 1'b0;
    @(negedge sd_clk);
    run_txn(6'd9, $urandom, 0, M_SHORT, 2, 1'b0, 1, rand_payload());

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
